// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding mux selects,
// halt-drain FSM states and the HLT opcode.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // The younger producer (MEM) wins over WB so the newest value is used.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        logic [1:0] w_sel;
        if (mem_hit) begin
            w_sel = FWD_MEM;
        end else if (wb_hit) begin
            w_sel = FWD_WB;
        end else begin
            w_sel = FWD_REG;
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select: compares one EX source register against the
// MEM and WB destinations. R0 is hardwired zero and never forwarded.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_wb_dst,
    input  logic             i_wb_regwrite,
    output logic [1:0]       o_fwd
);

    logic w_src_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nz  = (i_src != {REG_W{1'b0}});
    assign w_mem_hit = w_src_nz & i_mem_regwrite & (i_mem_dst == i_src);
    assign w_wb_hit  = w_src_nz & i_wb_regwrite & (i_wb_dst == i_src);
    assign o_fwd     = fwd_pick(w_mem_hit, w_wb_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage pipeline with halt-drain FSM.
// Optional perf counters (stall_cnt/flush_cnt) enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_id_src1,
    input  logic [REG_W-1:0] i_id_src2,
    input  logic             i_id_src1_vld,
    input  logic             i_id_src2_vld,
    input  logic             i_id_is_hlt,
    input  logic [REG_W-1:0] i_ex_src1,
    input  logic [REG_W-1:0] i_ex_src2,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic             i_ex_memtoreg,
    input  logic             i_ex_br_taken,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_wb_dst,
    input  logic             i_wb_regwrite,
    input  logic             i_imem_rdy,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_pc_wen,
    output logic             o_ifid_wen,
    output logic             o_idex_wen,
    output logic             o_exmem_wen,
    output logic             o_memwb_wen,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_memwb_flush,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_hlt
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
`endif
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_drain_cnt;
    logic [DW-1:0] w_drain_cnt_nxt;

    logic       w_mem_wait;
    logic       w_load_use;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_mem_wait = i_dmem_req & ~i_dmem_ack;
    assign w_load_use = i_ex_memtoreg & (i_ex_dst != {REG_W{1'b0}}) &
                        ((i_id_src1_vld & (i_id_src1 == i_ex_dst)) |
                         (i_id_src2_vld & (i_id_src2 == i_ex_dst)));

    pipe_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .i_src          (i_ex_src1),
        .i_mem_dst      (i_mem_dst),
        .i_mem_regwrite (i_mem_regwrite),
        .i_wb_dst       (i_wb_dst),
        .i_wb_regwrite  (i_wb_regwrite),
        .o_fwd          (w_fwd_a)
    );

    pipe_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .i_src          (i_ex_src2),
        .i_mem_dst      (i_mem_dst),
        .i_mem_regwrite (i_mem_regwrite),
        .i_wb_dst       (i_wb_dst),
        .i_wb_regwrite  (i_wb_regwrite),
        .o_fwd          (w_fwd_b)
    );

    // FSM state and drain counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_drain_cnt <= {DW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Next-state and prioritised stall/flush/forward outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        o_pc_wen        = 1'b1;
        o_ifid_wen      = 1'b1;
        o_idex_wen      = 1'b1;
        o_exmem_wen     = 1'b1;
        o_memwb_wen     = 1'b1;
        o_ifid_flush    = 1'b0;
        o_idex_flush    = 1'b0;
        o_memwb_flush   = 1'b0;
        o_hlt           = 1'b0;
        o_fwd_a         = w_fwd_a;
        o_fwd_b         = w_fwd_b;

        case (r_state)
            RUN: begin
                // HLT is accepted only when it actually leaves ID this cycle.
                if (i_id_is_hlt & ~w_mem_wait & ~i_ex_br_taken & ~w_load_use) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = {DW{1'b0}};
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_mem_wait) begin
                    w_drain_cnt_nxt = r_drain_cnt;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt     = HALTED;
                    w_drain_cnt_nxt = {DW{1'b0}};
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DW'(1);
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt     = RUN;
                w_drain_cnt_nxt = {DW{1'b0}};
            end
        endcase

        if (i_rst) begin
            o_fwd_a = FWD_REG;
            o_fwd_b = FWD_REG;
        end else if (r_state == HALTED) begin
            o_hlt       = 1'b1;
            o_pc_wen    = 1'b0;
            o_ifid_wen  = 1'b0;
            o_idex_wen  = 1'b0;
            o_exmem_wen = 1'b0;
            o_memwb_wen = 1'b0;
        end else if (w_mem_wait) begin
            o_pc_wen      = 1'b0;
            o_ifid_wen    = 1'b0;
            o_idex_wen    = 1'b0;
            o_exmem_wen   = 1'b0;
            o_memwb_flush = 1'b1;
        end else if (i_ex_br_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if ((r_state == DRAIN) | w_load_use) begin
            o_pc_wen     = 1'b0;
            o_ifid_wen   = 1'b0;
            o_idex_flush = 1'b1;
        end else if (~i_imem_rdy) begin
            o_pc_wen     = 1'b0;
            o_ifid_flush = 1'b1;
        end else begin
            o_pc_wen = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic             w_halted;
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Events follow the output priority so each cycle is counted once.
    assign w_halted    = (r_state == HALTED);
    assign w_stall_evt = ~w_halted & (w_mem_wait |
                         (~i_ex_br_taken & (r_state != DRAIN) & (w_load_use | ~i_imem_rdy)));
    assign w_flush_evt = ~w_halted & ~w_mem_wait & i_ex_br_taken;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // Saturating performance counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
